// File: rtl/dmem_unit.sv
// dmem_unit: word/half/byte data memory with a valid/ready request port and an RD_LAT-deep response pipe.
// Define DMEM_STORE_LOG_EN to print one trace line per successful store.
module dmem_unit #(
  parameter int DEPTH_WORDS = 3072,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH_WORDS);

  localparam logic [2:0] T_W  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_HU = 3'b010;
  localparam logic [2:0] T_B  = 3'b011;
  localparam logic [2:0] T_BU = 3'b100;

  // state | meaning
  // CLEAR | zero-fill sweep after reset, requests refused
  // RUN   | one request accepted per cycle
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;

  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             accept;
  logic             bad_align;
  logic             err;
  logic [31:0]      cur_word;
  logic [31:0]      merged;
  logic [31:0]      ld_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign idx      = req_addr[IDX_W+1:2];
  assign off      = req_addr[1:0];
  assign accept   = req_valid & req_ready;
  assign cur_word = mem[idx];

  always_comb begin
    bad_align = 1'b0;
    case (req_type)
      T_W:       bad_align = (off != 2'b00);
      T_H, T_HU: bad_align = off[0];
      T_B, T_BU: bad_align = 1'b0;
      default:   bad_align = 1'b1;
    endcase
  end

  assign err = bad_align | ({1'b0, idx} >= DEPTH_V);

  // HU/BU stores fall into the half/byte lanes, illegal types never write
  always_comb begin
    merged = cur_word;
    case (req_type)
      T_W:       merged = req_wdata;
      T_H, T_HU: merged[{off[1], 4'b0000} +: 16] = req_wdata[15:0];
      default:   merged[{off, 3'b000} +: 8] = req_wdata[7:0];
    endcase
  end

  assign ld_byte = cur_word[{off, 3'b000} +: 8];
  assign ld_half = cur_word[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = cur_word;
    case (req_type)
      T_H:     ld_data = {{16{ld_half[15]}}, ld_half};
      T_HU:    ld_data = {16'h0000, ld_half};
      T_B:     ld_data = {{24{ld_byte[7]}}, ld_byte};
      T_BU:    ld_data = {24'h000000, ld_byte};
      default: ld_data = cur_word;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
            state     <= RUN;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        default: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_idx] <= '0;
    else if (accept && req_we && !err)
      mem[idx] <= merged;
  end

  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_e;
  logic [31:0]       pipe_d [RD_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_d[k] <= '0;
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept & err;
      pipe_d[0] <= (accept && !req_we && !err) ? ld_data : 32'h0;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_e[k] <= pipe_e[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  assign rsp_valid = pipe_v[RD_LAT-1];
  assign rsp_err   = pipe_e[RD_LAT-1];
  assign rsp_rdata = pipe_d[RD_LAT-1];

`ifdef DMEM_STORE_LOG_EN
  always @(posedge clk) begin
    if (accept && req_we && !err)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
  end
`endif

  // PC and the address bits above the word index only matter for the store trace
  logic unused_bits;
  assign unused_bits = ^{req_pc, req_addr[31:IDX_W+2]};

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed and random traffic on an RD_LAT=3 instance, checked against a byte-array model.
module tb_dmem_unit;
  localparam int DEPTH = 3072;
  localparam int LAT   = 3;
  localparam int IDX_W = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  dmem_unit #(.DEPTH_WORDS(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [DEPTH*4];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rsp_total = 0;
  int          before_cnt;
  logic [31:0] last_data;
  logic        last_err;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_type;
  logic        r_we;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-level little-endian model of one access
  task automatic model(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] data);
    int     size;
    int     idx;
    int     base;
    longint val;
    size = (typ == 3'd0) ? 4 : (typ <= 3'd2) ? 2 : (typ <= 3'd4) ? 1 : 0;
    idx  = int'((addr / 4) % (1 << IDX_W));
    data = 32'h0;
    if (size == 0) err = 1'b1;
    else err = ((addr % size) != 0) || (idx >= DEPTH);
    if (err) return;
    base = idx * 4 + int'(addr % 4);
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[base + i] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val += longint'(ref_mem[base + i]) << (8 * i);
      if ((typ == 3'd1 || typ == 3'd3) && val >= (64'sd1 << (8 * size - 1)))
        val -= (64'sd1 << (8 * size));
      data = val[31:0];
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata);
    exp_t e;
    logic rdy;
    req_valid = 1'b1;
    req_we    = we;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = 32'h0040_0000 + addr;
    @(posedge clk);
    rdy = req_ready;
    if (rdy === 1'b1) begin
      e.cyc = cyc + LAT;
      model(we, typ, addr, wdata, e.err, e.data);
      exp_q.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
    last_data = 'x;
    last_err  = 1'bx;
    issue(we, typ, addr, wdata);
    repeat (LAT) @(negedge clk);
    #1;
    check({tag, ".data"}, last_data, exp_data);
    check({tag, ".err"}, 32'(last_err), 32'(exp_err));
  endtask

  task automatic sweep_wait(input string tag);
    int cnt = 0;
    for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      cnt++;
      check({tag, ".busy"}, 32'(busy), 32'd1);
    end
    req_valid = 1'b0;
    check({tag, ".len"}, cnt, DEPTH);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  // Response monitor: every cycle rsp_valid must match the head of the expectation queue
  always @(negedge clk) begin
    logic exp_v;
    exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check("rsp_rdata", rsp_rdata, exp_q[0].data);
      check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
      last_data = rsp_rdata;
      last_err  = rsp_err;
      rsp_total++;
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_type  = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_pc    = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);

    // Store held during the sweep must be ignored
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_type  = 3'd0;
    req_addr  = 32'h40;
    req_wdata = 32'h1234_5678;
    sweep_wait("sweep1");

    do_req("lw0", 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    do_req("held_ignored", 1'b0, 3'd0, 32'h40, 32'h0, 32'h0, 1'b0);

    issue(1'b1, 3'd0, 32'h10, 32'h1122_3344);
    issue(1'b1, 3'd3, 32'h12, 32'hFFFF_FFAA);
    do_req("lw_merge", 1'b0, 3'd0, 32'h10, 32'h0, 32'h11AA_3344, 1'b0);
    do_req("lw_alias", 1'b0, 3'd0, 32'h0001_0010, 32'h0, 32'h11AA_3344, 1'b0);

    do_req("sw20", 1'b1, 3'd0, 32'h20, 32'h8001_F07F, 32'h0, 1'b0);
    do_req("lb20", 1'b0, 3'd3, 32'h20, 32'h0, 32'h0000_007F, 1'b0);
    do_req("lb21", 1'b0, 3'd3, 32'h21, 32'h0, 32'hFFFF_FFF0, 1'b0);
    do_req("lbu21", 1'b0, 3'd4, 32'h21, 32'h0, 32'h0000_00F0, 1'b0);
    do_req("lh22", 1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    do_req("lhu22", 1'b0, 3'd2, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    do_req("shu22", 1'b1, 3'd2, 32'h22, 32'h7777_BEEF, 32'h0, 1'b0);
    do_req("sbu23", 1'b1, 3'd4, 32'h23, 32'h0000_0011, 32'h0, 1'b0);
    do_req("lw20", 1'b0, 3'd0, 32'h20, 32'h0, 32'h11EF_F07F, 1'b0);
    do_req("lh20", 1'b0, 3'd1, 32'h20, 32'h0, 32'hFFFF_F07F, 1'b0);

    do_req("sw0", 1'b1, 3'd0, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_req("sw_mis", 1'b1, 3'd0, 32'h2, 32'hDEAD_BEEF, 32'h0, 1'b1);
    do_req("lh_mis", 1'b0, 3'd1, 32'h1, 32'h0, 32'h0, 1'b1);
    do_req("bad_type", 1'b1, 3'd5, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    do_req("lw_oor", 1'b0, 3'd0, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1);
    do_req("sw_oor", 1'b1, 3'd0, 32'(DEPTH * 4), 32'hDEAD_BEEF, 32'h0, 1'b1);
    do_req("lw_last", 1'b0, 3'd0, 32'(DEPTH * 4 - 4), 32'h0, 32'h0, 1'b0);
    do_req("unchanged", 1'b0, 3'd0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Eight back-to-back loads; the monitor enforces the cycle-exact response slots
    before_cnt = rsp_total;
    for (int i = 0; i < 8; i++) issue(1'b0, 3'd0, 32'(4 * i), 32'h0);
    repeat (LAT + 1) @(negedge clk);
    check("b2b.count", rsp_total - before_cnt, 32'd8);

    for (int n = 0; n < 400; n++) begin
      r_type = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 15))
        0:       r_addr = 32'(DEPTH * 4 + $urandom_range(0, 63));
        1:       r_addr = 32'h8000_0000 | 32'($urandom_range(0, 127));
        default: r_addr = 32'($urandom_range(0, 127));
      endcase
      r_we   = 1'($urandom_range(0, 1));
      r_data = $urandom;
      issue(r_we, r_type, r_addr, r_data);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (LAT + 2) @(negedge clk);
    check("rand.drain", exp_q.size(), 32'd0);

    do_req("pre_rst_sw", 1'b1, 3'd0, 32'h10, 32'h5555_AAAA, 32'h0, 1'b0);
    before_cnt = rsp_total;
    issue(1'b0, 3'd0, 32'h10, 32'h0);
    issue(1'b0, 3'd0, 32'h20, 32'h0);
    reset = 1'b1;
    exp_q.delete();
    repeat (LAT + 2) @(negedge clk);
    check("flush.count", rsp_total - before_cnt, 32'd0);
    check("flush.busy", 32'(busy), 32'd1);
    check("flush.ready", 32'(req_ready), 32'd0);
    sweep_wait("sweep2");
    do_req("lw10_cleared", 1'b0, 3'd0, 32'h10, 32'h0, 32'h0, 1'b0);
    do_req("lw20_cleared", 1'b0, 3'd0, 32'h20, 32'h0, 32'h0, 1'b0);

    repeat (LAT + 2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
